// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
package mod_exp_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 256;
  localparam int unsigned EXP_WIDTH_DEFAULT = 256;

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    RED_REQ,
    RED_WAIT,
    SQ_REQ,
    SQ_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DONE
  } state_t;

  // Which operand pair is presented to the external multiplier.
  typedef enum logic [1:0] {
    OP_RED,
    OP_SQ,
    OP_MUL
  } op_sel_t;

  // Width of a down-counter able to hold w-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/exp_bit_scan.sv
// Exponent shift register and bit counter for the square-and-multiply walk.
module exp_bit_scan
  import mod_exp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEFAULT,
  parameter int unsigned CNT_W     = cnt_width(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [EXP_WIDTH-1:0] e_in,
  input  logic                 shift,
  input  logic                 dec,
  output logic                 msb,
  output logic                 cnt_zero
);

  logic [EXP_WIDTH-1:0] e_sh;
  logic [CNT_W-1:0]     cnt;

  // Load on accept; otherwise shift toward the MSB and count down on request.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_sh <= '0;
      cnt  <= '0;
    end else if (load) begin
      e_sh <= e_in;
      cnt  <= CNT_W'(EXP_WIDTH - 1);
    end else begin
      if (shift) e_sh <= e_sh << 1;
      if (dec)   cnt  <= cnt - 1'b1;
    end
  end

  assign msb      = e_sh[EXP_WIDTH-1];
  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Modular-exponentiation sequencer: M = y^e mod n, left-to-right
// square-and-multiply, every multiply issued to an external mul_mod.
// Build option: MOD_EXP_CT_EN selects the constant-time sequence.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [WIDTH-1:0]     y,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  output logic [WIDTH-1:0]     M,
  output logic                 valid,
  output logic                 busy,
  output logic [WIDTH-1:0]     mm_y,
  output logic [WIDTH-1:0]     mm_z,
  output logic [WIDTH-1:0]     mm_n,
  output logic                 mm_ready,
  input  logic [WIDTH-1:0]     mm_M,
  input  logic                 mm_valid
);

  state_t           state, state_nxt;
  op_sel_t          op_sel;
  logic             op_active;

  logic [WIDTH-1:0] y_q, n_q, r_q, b_q, m_q;
  logic [WIDTH-1:0] r_nxt;
  logic             load, shift, dec, b_load;
  logic             msb, cnt_zero;
`ifdef MOD_EXP_CT_EN
  logic             bit_q, bit_nxt;
`endif

  exp_bit_scan #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .e_in     (e),
    .shift    (shift),
    .dec      (dec),
    .msb      (msb),
    .cnt_zero (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode.
  // The counter steps down at SQ_REQ rather than at the SQ result so that
  // cnt_zero already reflects the post-step count when the square returns.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    dec       = 1'b0;
    b_load    = 1'b0;
    r_nxt     = r_q;
    mm_ready  = 1'b0;
`ifdef MOD_EXP_CT_EN
    bit_nxt   = bit_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (ready) begin
          load = 1'b1;
`ifdef MOD_EXP_CT_EN
          r_nxt     = WIDTH'(1);
          state_nxt = RED_REQ;
`else
          if (e == '0) begin
            r_nxt     = WIDTH'(1);
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
          end
`endif
        end
      end
      SCAN: begin
        shift = 1'b1;
        if (msb) state_nxt = RED_REQ;
        else     dec       = 1'b1;
      end
      RED_REQ: begin
        mm_ready  = 1'b1;
        state_nxt = RED_WAIT;
      end
      RED_WAIT: begin
        if (mm_valid) begin
          b_load = 1'b1;
`ifdef MOD_EXP_CT_EN
          r_nxt     = WIDTH'(1);
          state_nxt = SQ_REQ;
`else
          r_nxt     = mm_M;
          state_nxt = cnt_zero ? DONE : SQ_REQ;
`endif
        end
      end
      SQ_REQ: begin
        mm_ready  = 1'b1;
`ifndef MOD_EXP_CT_EN
        dec       = 1'b1;
`endif
        state_nxt = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mm_valid) begin
          r_nxt = mm_M;
          shift = 1'b1;
`ifdef MOD_EXP_CT_EN
          bit_nxt   = msb;
          state_nxt = MUL_REQ;
`else
          if (msb)           state_nxt = MUL_REQ;
          else if (cnt_zero) state_nxt = DONE;
          else               state_nxt = SQ_REQ;
`endif
        end
      end
      MUL_REQ: begin
        mm_ready  = 1'b1;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mm_valid) begin
`ifdef MOD_EXP_CT_EN
          if (bit_q) r_nxt = mm_M;
          if (cnt_zero) begin
            state_nxt = DONE;
          end else begin
            dec       = 1'b1;
            state_nxt = SQ_REQ;
          end
`else
          r_nxt     = mm_M;
          state_nxt = cnt_zero ? DONE : SQ_REQ;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
      n_q <= '0;
      r_q <= '0;
      b_q <= '0;
      m_q <= '0;
`ifdef MOD_EXP_CT_EN
      bit_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        y_q <= y;
        n_q <= n;
      end
      r_q <= r_nxt;
      if (b_load) b_q <= mm_M;
      if (state_nxt == DONE && (state != DONE || load)) m_q <= r_nxt;
`ifdef MOD_EXP_CT_EN
      bit_q <= bit_nxt;
`endif
    end
  end

  // Operand selection follows the state, so it is stable from REQ through WAIT.
  always_comb begin
    op_active = 1'b1;
    op_sel    = OP_RED;
    case (state)
      RED_REQ, RED_WAIT: op_sel = OP_RED;
      SQ_REQ,  SQ_WAIT:  op_sel = OP_SQ;
      MUL_REQ, MUL_WAIT: op_sel = OP_MUL;
      default:           op_active = 1'b0;
    endcase
  end

  // Multiplier operand mux; idle states present zeros.
  always_comb begin
    mm_y = '0;
    mm_z = '0;
    mm_n = '0;
    if (op_active) begin
      mm_n = n_q;
      case (op_sel)
        OP_RED: begin
          mm_y = y_q;
          mm_z = WIDTH'(1);
        end
        OP_SQ: begin
          mm_y = r_q;
          mm_z = r_q;
        end
        default: begin
          mm_y = r_q;
          mm_z = b_q;
        end
      endcase
    end
  end

  assign M     = m_q;
  assign valid = (state == DONE);
  assign busy  = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural mul_mod responder.
module tb_mod_exp_ctrl;

  localparam int W  = 16;
  localparam int EW = 16;

`ifdef MOD_EXP_CT_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic [W-1:0]  y = '0;
  logic [EW-1:0] e = '0;
  logic [W-1:0]  n = '0;
  logic [W-1:0]  M;
  logic          valid, busy;
  logic [W-1:0]  mm_y, mm_z, mm_n;
  logic          mm_ready;
  logic [W-1:0]  mm_M = '0;
  logic          mm_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // responder state
  int           pulse_total = 0;
  int           stab_errs = 0;
  int           cd = 0;
  bit           lat_rand = 1'b0;
  logic [W-1:0] pa, pb, pn;

  mod_exp_ctrl #(
    .WIDTH     (W),
    .EXP_WIDTH (EW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .y        (y),
    .e        (e),
    .n        (n),
    .M        (M),
    .valid    (valid),
    .busy     (busy),
    .mm_y     (mm_y),
    .mm_z     (mm_z),
    .mm_n     (mm_n),
    .mm_ready (mm_ready),
    .mm_M     (mm_M),
    .mm_valid (mm_valid)
  );

  always #5 clk = ~clk;

  // mul_mod model: latch on request, answer after fixed or random latency.
  always @(posedge clk) begin
    if (reset) begin
      mm_valid <= 1'b0;
      cd       <= 0;
    end else if (mm_ready) begin
      pulse_total <= pulse_total + 1;
      pa <= mm_y;
      pb <= mm_z;
      pn <= mm_n;
      mm_valid <= 1'b0;
      cd <= lat_rand ? int'($urandom_range(1, 6)) : 3;
    end else if (cd > 0) begin
      if (mm_y !== pa || mm_z !== pb || mm_n !== pn) stab_errs <= stab_errs + 1;
      cd <= cd - 1;
      if (cd == 1) begin
        mm_valid <= 1'b1;
        mm_M <= (pn == '0) ? '0 : W'((longint'(pa) * longint'(pb)) % longint'(pn));
      end
    end
  end

  function automatic logic [W-1:0] ref_exp(input longint unsigned b, input logic [EW-1:0] ex,
                                           input longint unsigned md);
    longint unsigned r = 1;
    b = b % md;
    for (int i = 0; i < EW; i++) begin
      if (ex[i]) r = (r * b) % md;
      b = (b * b) % md;
    end
    return W'(r % md);
  endfunction

  function automatic int exp_pulses(input logic [EW-1:0] ex);
    int bl = 0;
    int pc = 0;
    if (CT) return 1 + 2 * EW;
    if (ex == '0) return 0;
    for (int i = 0; i < EW; i++) begin
      if (ex[i]) begin
        bl = i + 1;
        pc++;
      end
    end
    return 1 + (bl - 1) + (pc - 1);
  endfunction

  task automatic run_exp(input logic [W-1:0] ty, input logic [EW-1:0] te, input logic [W-1:0] tn,
                         output int npulse, output int ncyc, output bit tmo);
    int p0;
    p0 = pulse_total;
    @(posedge clk); #1;
    y = ty; e = te; n = tn; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    ncyc = 1;
    while (!valid && ncyc < 3000) begin
      @(posedge clk); #1;
      ncyc++;
    end
    tmo = !valid;
    npulse = pulse_total - p0;
  endtask

  task automatic check_run(input string tag, input logic [W-1:0] ty, input logic [EW-1:0] te,
                           input logic [W-1:0] tn, input logic [W-1:0] expm, input int expp);
    int np, nc, s0;
    bit tmo;
    s0 = stab_errs;
    run_exp(ty, te, tn, np, nc, tmo);
    vectors++;
    if (tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: valid never rose within %0d cycles", tag, nc);
    end
    vectors++;
    if (M !== expm) begin
      miscompares++;
      $display("FAIL %s_M: got %0d expected %0d", tag, M, expm);
    end
    vectors++;
    if (np !== expp) begin
      miscompares++;
      $display("FAIL %s_pulses: got %0d expected %0d", tag, np, expp);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy: got %b expected 0", tag, busy);
    end
    vectors++;
    if (stab_errs - s0 !== 0) begin
      miscompares++;
      $display("FAIL %s_stable: %0d operand changes during wait, expected 0", tag, stab_errs - s0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({M, valid, busy, mm_ready} !== {W'(0), 3'b000}) begin
      miscompares++;
      $display("FAIL reset_out: M=%0d valid=%b busy=%b mm_ready=%b expected 0/0/0/0",
               M, valid, busy, mm_ready);
    end
    vectors++;
    if ({mm_y, mm_z, mm_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_mm: mm_y=%0d mm_z=%0d mm_n=%0d expected 0", mm_y, mm_z, mm_n);
    end
  endtask

  task automatic test_basic();
    check_run("basic", 16'd4, 16'd13, 16'd497, 16'd445, CT ? 33 : 6);
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_valid: got %b expected 1", valid);
    end
  endtask

  task automatic test_reduce();
    check_run("reduce", 16'd600, 16'd1, 16'd497, 16'd103, CT ? 33 : 1);
  endtask

  task automatic test_zero_exp();
    int np, nc;
    bit tmo;
    run_exp(16'd5, 16'd0, 16'd7, np, nc, tmo);
    vectors++;
    if (M !== 16'd1 || tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_M: got %0d (timeout %b) expected 1", M, tmo);
    end
    vectors++;
    if (np !== (CT ? 33 : 0)) begin
      miscompares++;
      $display("FAIL zero_pulses: got %0d expected %0d", np, CT ? 33 : 0);
    end
    if (!CT) begin
      vectors++;
      if (nc > 3) begin
        miscompares++;
        $display("FAIL zero_latency: got %0d cycles expected <= 3", nc);
      end
    end
  endtask

  task automatic test_back_to_back();
    // previous run left the block in DONE; accept must drop valid next cycle
    @(posedge clk); #1;
    y = 16'd7; e = 16'd5; n = 16'd11; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: valid=%b busy=%b expected 0/1", valid, busy);
    end
    check_run("b2b", 16'd7, 16'd5, 16'd11, 16'd10, CT ? 33 : 4);
  endtask

  task automatic test_ready_ignored();
    int p0, nc;
    p0 = pulse_total;
    @(posedge clk); #1;
    y = 16'd4; e = 16'd13; n = 16'd497; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    y = 16'd9; e = 16'd3; n = 16'd11; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    nc = 0;
    while (!valid && nc < 3000) begin
      @(posedge clk); #1;
      nc++;
    end
    vectors++;
    if (valid !== 1'b1 || M !== 16'd445) begin
      miscompares++;
      $display("FAIL ignored_M: got %0d valid=%b expected 445 valid=1", M, valid);
    end
    vectors++;
    if (pulse_total - p0 !== (CT ? 33 : 6)) begin
      miscompares++;
      $display("FAIL ignored_pulses: got %0d expected %0d", pulse_total - p0, CT ? 33 : 6);
    end
  endtask

  task automatic test_exp_extremes();
    check_run("allones", 16'd4, 16'hFFFF, 16'd497, ref_exp(4, 16'hFFFF, 497), exp_pulses(16'hFFFF));
    check_run("one", 16'd4, 16'h0001, 16'd497, 16'd4, CT ? 33 : 1);
  endtask

  task automatic test_reset_mid_run();
    int seen, nc, p0;
    seen = 0;
    nc = 0;
    @(posedge clk); #1;
    y = 16'd4; e = 16'd13; n = 16'd497; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    // second request is the first square; one cycle later the block is in SQ_WAIT
    while (seen < 2 && nc < 200) begin
      if (mm_ready) seen++;
      if (seen < 2) begin
        @(posedge clk); #1;
      end
      nc++;
    end
    vectors++;
    if (seen !== 2) begin
      miscompares++;
      $display("FAIL midrst_reach: saw %0d requests expected 2", seen);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({valid, busy, mm_ready} !== 3'b000 || M !== '0) begin
      miscompares++;
      $display("FAIL midrst_out: valid=%b busy=%b mm_ready=%b M=%0d expected 0/0/0/0",
               valid, busy, mm_ready, M);
    end
    reset = 1'b0;
    p0 = pulse_total;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (pulse_total - p0 !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet: %0d requests busy=%b after reset expected 0/0",
               pulse_total - p0, busy);
    end
  endtask

  task automatic test_random_latency();
    lat_rand = 1'b1;
    check_run("rand1", 16'd4, 16'd13, 16'd497, 16'd445, CT ? 33 : 6);
    check_run("rand2", 16'd123, 16'hA5C3, 16'd50021, ref_exp(123, 16'hA5C3, 50021), CT ? 33 : 23);
    lat_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reduce();
    test_zero_exp();
    test_back_to_back();
    test_ready_ignored();
    test_exp_extremes();
    test_reset_mid_run();
    test_random_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
